// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register with valid/ready handshake and a 2-entry skid buffer.
//
// The main entry drives ex_*. The skid entry catches one instruction that was
// accepted while EXE was stalling. id_ready is a flop, so EXE back-pressure never
// reaches ID through combinational logic. The flush input squashes both entries
// and drops any instruction offered in the same cycle. stall_cnt counts the
// cycles where EXE holds a valid head entry without consuming it, and stops at
// its maximum value.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id_valid/id_ready   upstream handshake (id_ready is registered)
//   id_*                decoded instruction fields from the ID stage
//   flush               squash held and incoming entries
//   ex_valid/ex_ready   downstream handshake
//   ex_*                head-entry fields for the ALU stage
//   stall_cnt           saturating back-pressure cycle count
module id_exe_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ALUC_W = 4,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              id_wmem,
  input  logic [ALUC_W-1:0] id_aluc,
  input  logic              id_aluimm,
  input  logic [DATA_W-1:0] id_qa,
  input  logic [DATA_W-1:0] id_qb,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic              ex_wreg,
  output logic              ex_m2reg,
  output logic              ex_wmem,
  output logic [ALUC_W-1:0] ex_aluc,
  output logic              ex_aluimm,
  output logic [DATA_W-1:0] ex_qa,
  output logic [DATA_W-1:0] ex_qb,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int ENT_W = 4 + ALUC_W + 3 * DATA_W + REG_AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [ENT_W-1:0] id_ent;
  logic [ENT_W-1:0] main_ent;
  logic [ENT_W-1:0] skid_ent;
  logic             main_vld;
  logic             skid_vld;
  logic             ready_q;
  logic             accept;
  logic             consume;
  logic             main_free;
  logic             main_wreg;
  logic             main_m2reg;
  logic             main_wmem;

  assign id_ent = {id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm,
                   id_qa, id_qb, id_imm, id_rd};

  assign {main_wreg, main_m2reg, main_wmem, ex_aluc, ex_aluimm,
          ex_qa, ex_qb, ex_imm, ex_rd} = main_ent;

  assign accept    = id_valid && ready_q;
  assign consume   = main_vld && ex_ready;
  // The main entry can take new data this edge if it is empty or is being drained.
  assign main_free = !main_vld || consume;

  assign id_ready = ready_q;
  assign ex_valid = main_vld;

  // The side-effect controls are gated so that a bubble can never write state.
  // The data fields stay as they are, so they do not toggle.
  assign ex_wreg  = main_wreg  && main_vld;
  assign ex_m2reg = main_m2reg && main_vld;
  assign ex_wmem  = main_wmem  && main_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_ent <= '0;
      skid_ent <= '0;
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      ready_q  <= 1'b1;
    end else if (flush) begin
      main_vld <= 1'b0;
      skid_vld <= 1'b0;
      ready_q  <= 1'b1;
    end else if (main_free) begin
      if (skid_vld) begin
        // Promote the skid entry first to keep FIFO order. ready_q is low while
        // the skid is full, so the accept branch only covers the general case.
        main_ent <= skid_ent;
        main_vld <= 1'b1;
        skid_vld <= accept;
        ready_q  <= !accept;
        if (accept) begin
          skid_ent <= id_ent;
        end
      end else begin
        main_vld <= accept;
        ready_q  <= 1'b1;
        if (accept) begin
          main_ent <= id_ent;
        end
      end
    end else if (accept) begin
      skid_ent <= id_ent;
      skid_vld <= 1'b1;
      ready_q  <= 1'b0;
    end
  end

  // The counter is not cleared by flush, so it keeps the stall history across squashes.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_vld && !ex_ready && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
module tb_id_exe_pipe_reg;

  localparam int DATA_W = 32;
  localparam int ALUC_W = 4;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              id_valid;
  logic              id_ready;
  logic              id_wreg;
  logic              id_m2reg;
  logic              id_wmem;
  logic [ALUC_W-1:0] id_aluc;
  logic              id_aluimm;
  logic [DATA_W-1:0] id_qa;
  logic [DATA_W-1:0] id_qb;
  logic [DATA_W-1:0] id_imm;
  logic [REG_AW-1:0] id_rd;
  logic              flush;
  logic              ex_valid;
  logic              ex_ready;
  logic              ex_wreg;
  logic              ex_m2reg;
  logic              ex_wmem;
  logic [ALUC_W-1:0] ex_aluc;
  logic              ex_aluimm;
  logic [DATA_W-1:0] ex_qa;
  logic [DATA_W-1:0] ex_qb;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rd;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  id_exe_pipe_reg #(
    .DATA_W(DATA_W), .ALUC_W(ALUC_W), .REG_AW(REG_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_wreg(id_wreg), .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm),
    .id_qa(id_qa), .id_qb(id_qb), .id_imm(id_imm), .id_rd(id_rd),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_aluc(ex_aluc), .ex_aluimm(ex_aluimm),
    .ex_qa(ex_qa), .ex_qb(ex_qb), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .stall_cnt(stall_cnt)
  );

  typedef struct {
    logic [31:0] qa;
    logic        wreg;
    logic        wmem;
  } ent_t;

  ent_t       sb[$];
  int         vecs = 0;
  int         miss = 0;
  logic [2:0] m_stall = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] qa, input logic wr, input logic wm);
    id_valid = v;
    id_qa    = qa;
    id_wreg  = wr;
    id_wmem  = wm;
    id_rd    = qa[4:0];
  endtask

  // Check outputs against the model (mid-cycle), then advance the model and the clock.
  task automatic tick();
    ent_t e;
    bit   acc;
    bit   cons;
    chk("id_ready", {31'd0, id_ready}, {31'd0, sb.size() < 2});
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, sb.size() > 0});
    chk("stall_cnt", {29'd0, stall_cnt}, {29'd0, m_stall});
    if (sb.size() > 0) begin
      chk("ex_qa", ex_qa, sb[0].qa);
      chk("ex_wreg", {31'd0, ex_wreg}, {31'd0, sb[0].wreg});
      chk("ex_wmem", {31'd0, ex_wmem}, {31'd0, sb[0].wmem});
    end else begin
      chk("bubble_wreg", {31'd0, ex_wreg}, 32'd0);
      chk("bubble_m2reg", {31'd0, ex_m2reg}, 32'd0);
      chk("bubble_wmem", {31'd0, ex_wmem}, 32'd0);
    end
    acc  = id_valid && (sb.size() < 2);
    cons = (sb.size() > 0) && ex_ready;
    if (rst) begin
      sb.delete();
      m_stall = 3'd0;
    end else begin
      if ((sb.size() > 0) && !ex_ready && (m_stall != 3'd7)) m_stall++;
      if (flush) begin
        sb.delete();
      end else begin
        if (cons) void'(sb.pop_front());
        if (acc) begin
          e.qa   = id_qa;
          e.wreg = id_wreg;
          e.wmem = id_wmem;
          sb.push_back(e);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    ex_ready  = 1'b0;
    id_m2reg  = 1'b0;
    id_aluc   = '0;
    id_aluimm = 1'b0;
    id_qb     = '0;
    id_imm    = '0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ex_qa", ex_qa, 32'd0);
    chk("rst_ex_rd", {27'd0, ex_rd}, 32'd0);

    // Stream at full rate.
    ex_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) tick();

    // Back-pressure fills main and skid, and 0xC waits at ID.
    ex_ready = 1'b0;
    drive(1'b1, 32'hA, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hB, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hC, 1'b0, 1'b0); tick();
    tick();
    ex_ready = 1'b1;
    tick();
    tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (2) tick();

    // Flush with both entries full, and 0x55 offered in the same cycle.
    ex_ready = 1'b0;
    drive(1'b1, 32'hD1, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hD2, 1'b0, 1'b0); tick();
    drive(1'b1, 32'h55, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    ex_ready = 1'b1;
    repeat (2) tick();

    // Bubble gating.
    drive(1'b1, 32'h77, 1'b1, 1'b1); tick();
    drive(1'b0, 32'h77, 1'b1, 1'b1); tick();
    repeat (2) tick();

    // Counter saturation, which survives flush and is cleared by reset.
    rst = 1'b1; tick(); rst = 1'b0;
    ex_ready = 1'b0;
    drive(1'b1, 32'h9, 1'b0, 1'b0); tick();
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    repeat (10) tick();
    chk("stall_sat", {29'd0, stall_cnt}, 32'd7);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("stall_after_flush", {29'd0, stall_cnt}, 32'd7);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("stall_after_rst", {29'd0, stall_cnt}, 32'd0);

    // Reset in the middle of operation, together with flush and an offered entry.
    drive(1'b1, 32'hE1, 1'b1, 1'b0); tick();
    drive(1'b1, 32'hE2, 1'b0, 1'b1); tick();
    drive(1'b1, 32'hE3, 1'b1, 1'b1);
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0);
    chk("midrst_ex_qa", ex_qa, 32'd0);
    chk("midrst_ex_rd", {27'd0, ex_rd}, 32'd0);
    chk("midrst_id_ready", {31'd0, id_ready}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
